// File: rtl/rpm_pkg.sv
// Shared types and default parameters for the RPM measurement path (gate controller and pulse counter).
package rpm_pkg;

    localparam int unsigned DEF_CNT_W         = 4;
    localparam int unsigned DEF_WINDOW_CYCLES = 50_000_000;
    localparam int unsigned DEF_RPM_SCALE     = 60;
    localparam int unsigned DEF_SCALE_W       = 8;
    localparam int unsigned DEF_RPM_W         = 12;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        SAMPLE,
        MULT,
        OUT
    } state_e;

endpackage

// File: rtl/rpm_gate_ctrl_if.sv
// Counter-facing and result-facing signals of the RPM gate controller.
interface rpm_gate_ctrl_if
    import rpm_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned RPM_W = DEF_RPM_W
);
    logic             run;
    logic [CNT_W-1:0] count_in;
    logic             count_en;
    logic             done;
    logic [RPM_W-1:0] rpm_out;
    logic             rpm_valid;
    logic             rpm_ovf;
    logic             busy;

    modport master (
        output run, count_in,
        input  count_en, done, rpm_out, rpm_valid, rpm_ovf, busy
    );

    modport slave (
        input  run, count_in,
        output count_en, done, rpm_out, rpm_valid, rpm_ovf, busy
    );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential LSB-first shift-add multiply of a CNT_W operand by a constant; CNT_W cycles after start.
// done_o marks the final step; product_o is the full-width result valid on that cycle.
module shift_add_mult #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned SCALE_W = 8,
    parameter int unsigned SCALE   = 60
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [CNT_W-1:0]         mplier_i,
    output logic                     done_o,
    output logic [CNT_W+SCALE_W-1:0] product_o
);
    localparam int unsigned PROD_W = CNT_W + SCALE_W;
    localparam int unsigned STEP_W = $clog2(CNT_W + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CNT_W - 1);

    logic [CNT_W-1:0]  mplier_q;
    logic [PROD_W-1:0] mcand_q;
    logic [PROD_W-1:0] acc_q;
    logic [STEP_W-1:0] step_q;
    logic              active_q;

    // Accumulator value after the current step; on the last step this is the result.
    assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = active_q && (step_q == STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            mplier_q <= mplier_i;
            mcand_q  <= PROD_W'(SCALE);
            acc_q    <= '0;
            step_q   <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            acc_q    <= product_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            step_q   <= step_q + 1'b1;
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rpm_gate_ctrl.sv
// Gate-window sequencer driving the pulse counter, then scales the captured count to RPM.
// Result strobes WINDOW_CYCLES+CNT_W+1 cycles after gate open; no backpressure, run re-arms back-to-back.
module rpm_gate_ctrl
    import rpm_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned RPM_SCALE     = DEF_RPM_SCALE,
    parameter int unsigned SCALE_W       = DEF_SCALE_W,
    parameter int unsigned RPM_W         = DEF_RPM_W
) (
    input  logic            clk,
    input  logic            rst,
    rpm_gate_ctrl_if.slave  bus
);
    localparam int unsigned PROD_W = CNT_W + SCALE_W;
    localparam int unsigned WIN_W  = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    if (RPM_W < PROD_W) begin : g_rpm_w_check
        $error("RPM_W must be at least CNT_W + SCALE_W");
    end
    if (WINDOW_CYCLES < 2) begin : g_window_check
        $error("WINDOW_CYCLES must be at least 2");
    end

    state_e            state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              ovf_cap_q;
    logic [RPM_W-1:0]  rpm_q;
    logic              rpm_ovf_q;
    logic              mul_done;
    logic [PROD_W-1:0] mul_prod;

    shift_add_mult #(
        .CNT_W   (CNT_W),
        .SCALE_W (SCALE_W),
        .SCALE   (RPM_SCALE)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start_i   (state_q == SAMPLE),
        .mplier_i  (bus.count_in),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = GATE;
                    win_d   = '0;
                end
            end
            GATE: begin
                // A started window always runs to completion regardless of run.
                if (win_q == WIN_LAST) begin
                    state_d = SAMPLE;
                    win_d   = '0;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            SAMPLE:  state_d = MULT;
            MULT:    if (mul_done) state_d = OUT;
            OUT: begin
                state_d = bus.run ? GATE : IDLE;
                win_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            win_q     <= '0;
            ovf_cap_q <= 1'b0;
            rpm_q     <= '0;
            rpm_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            if (state_q == SAMPLE) begin
                ovf_cap_q <= &bus.count_in;
            end
            // Load on the edge entering OUT so the strobe and the new value coincide.
            if (state_q == MULT && mul_done) begin
                rpm_q     <= RPM_W'(mul_prod);
                rpm_ovf_q <= ovf_cap_q;
            end
        end
    end

    assign bus.count_en  = (state_q == GATE);
    assign bus.done      = (state_q == SAMPLE);
    assign bus.rpm_valid = (state_q == OUT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rpm_out   = rpm_q;
    assign bus.rpm_ovf   = rpm_ovf_q;

endmodule

// File: tb/tb_rpm_gate_ctrl.sv
// Scoreboard bench for rpm_gate_ctrl with a behavioural pulse counter and a 20-cycle gate window.
module tb_rpm_gate_ctrl;
    import rpm_pkg::*;

    localparam int unsigned CNT_W = DEF_CNT_W;
    localparam int unsigned RPM_W = DEF_RPM_W;
    localparam int unsigned WIN   = 20;
    localparam int unsigned SCALE = DEF_RPM_SCALE;

    typedef struct {
        logic [RPM_W-1:0] rpm;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rpm_gate_ctrl_if #(.CNT_W(CNT_W), .RPM_W(RPM_W)) bus ();

    rpm_gate_ctrl #(
        .CNT_W         (CNT_W),
        .WINDOW_CYCLES (WIN),
        .RPM_SCALE     (SCALE),
        .SCALE_W       (DEF_SCALE_W),
        .RPM_W         (RPM_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic             pulse     = 1'b0;
    logic             force_en  = 1'b0;
    logic [CNT_W-1:0] force_val = '0;
    logic [CNT_W-1:0] pcnt_q    = '0;

    // Pulse counter stand-in: counts while enabled, cleared by the done strobe.
    always_ff @(posedge clk) begin
        if (rst || bus.done)
            pcnt_q <= '0;
        else if (bus.count_en && pulse)
            pcnt_q <= pcnt_q + 1'b1;
    end
    assign bus.count_in = force_en ? force_val : pcnt_q;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t e_mon;
    int cyc = 0;
    int gate_start = 0;
    int done_cnt = 0;
    logic prev_en = 1'b0;
    logic [RPM_W-1:0] last_rpm = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.count_en && !prev_en) begin
                gate_start = cyc;
                done_cnt   = 0;
            end
            if (bus.done) begin
                done_cnt++;
                check("done_cycle", cyc - gate_start, WIN);
            end
            if (bus.rpm_valid) begin
                check("valid_cycle", cyc - gate_start, WIN + 1 + CNT_W);
                check("done_once", done_cnt, 1);
                check("valid_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    check("rpm_out", bus.rpm_out, e_mon.rpm);
                    check("rpm_ovf", bus.rpm_ovf, e_mon.ovf);
                    last_rpm = e_mon.rpm;
                end
            end
        end
        prev_en = bus.count_en;
    end

    task automatic push_exp(input int pulses);
        exp_t x;
        x.rpm = RPM_W'(pulses * SCALE);
        x.ovf = (pulses == (1 << CNT_W) - 1);
        exp_q.push_back(x);
    endtask

    task automatic wait_gate(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.count_en && lat < 100);
        check("gate_seen", bus.count_en, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rpm_valid && n < 100);
        check("valid_seen", bus.rpm_valid, 1);
    endtask

    task automatic send_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulse = 1'b1;
            @(negedge clk);
            pulse = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_count_en", bus.count_en, 0);
        end
        check("rpm_hold", bus.rpm_out, last_rpm);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_count_en"}, bus.count_en, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rpm_valid"}, bus.rpm_valid, 0);
        check({tag, "_rpm_ovf"}, bus.rpm_ovf, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_rpm_out"}, bus.rpm_out, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int g1;
        bus.run = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Five pulses in one window, then back to idle.
        push_exp(5);
        bus.run = 1'b1;
        wait_gate(lat);
        check("gate_latency", lat, 1);
        bus.run = 1'b0;
        send_pulses(5);
        wait_valid();
        check_idle(4);

        // Empty window still produces a zero result.
        push_exp(0);
        bus.run = 1'b1;
        wait_gate(lat);
        bus.run = 1'b0;
        wait_valid();
        check_idle(3);

        // All-ones count flags possible wrap.
        push_exp(15);
        force_val = 4'hF;
        force_en  = 1'b1;
        bus.run   = 1'b1;
        wait_gate(lat);
        bus.run = 1'b0;
        wait_valid();
        force_en = 1'b0;
        check_idle(3);

        // Back-to-back windows with run held high.
        push_exp(2);
        push_exp(4);
        bus.run = 1'b1;
        wait_gate(lat);
        g1 = cyc;
        send_pulses(2);
        wait_valid();
        wait_gate(lat);
        check("b2b_gate_rise", cyc - g1, WIN + 2 + CNT_W);
        bus.run = 1'b0;
        send_pulses(4);
        wait_valid();
        check_idle(3);

        // run dropped mid-window: window completes, then idle.
        push_exp(3);
        bus.run = 1'b1;
        wait_gate(lat);
        send_pulses(1);
        repeat (2) @(negedge clk);
        bus.run = 1'b0;
        send_pulses(2);
        wait_valid();
        check_idle(5);

        // Reset during the multiply discards the in-flight result.
        bus.run = 1'b1;
        wait_gate(lat);
        g1 = cyc;
        bus.run = 1'b0;
        send_pulses(3);
        while (cyc - g1 < 22) @(negedge clk);
        check("mult_busy", bus.busy, 1);
        check("mult_count_en", bus.count_en, 0);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("midrst");
        rst = 1'b0;
        last_rpm = '0;
        check_idle(6);

        // Restart after reset.
        push_exp(4);
        bus.run = 1'b1;
        wait_gate(lat);
        bus.run = 1'b0;
        send_pulses(4);
        wait_valid();
        check_idle(2);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpm_gate_ctrl.md
# rpm_gate_ctrl

Measurement sequencer and scaler for the RPM path; sits directly downstream of (and drives) the hall-pulse counter. Opens a fixed gate window by asserting `count_en`, closes it with a one-cycle `done` while capturing the counter's final value, then converts pulses-per-window to RPM with a sequential shift-add multiply by a constant scale. Produces a registered `rpm_out` with a one-cycle `rpm_valid` strobe per window, free-running while `run` is high.

## Interface
- `CNT_W`, 4: width of `count_in`; must match the pulse counter width.
- `WINDOW_CYCLES`, 50_000_000: gate length in `clk` cycles (1 s at 50 MHz); must be ≥ 2.
- `RPM_SCALE`, 60: RPM per counted pulse, equal to 60 / (pulses_per_rev × window_seconds), precomputed integer.
- `SCALE_W`, 8: width holding `RPM_SCALE`.
- `RPM_W`, 12: output width; must be ≥ `CNT_W + SCALE_W`, checked at elaboration.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; high = keep measuring back-to-back windows.
- `count_in`  in  CNT_W  counter value (pulse counter `count_out`).
- `count_en`  out  1  high for exactly the gate window.
- `done`  out  1  one-cycle close/clear strobe to the counter.
- `rpm_out`  out  RPM_W  last computed RPM, held until next result.
- `rpm_valid`  out  1  one-cycle strobe: `rpm_out` updated this cycle.
- `rpm_ovf`  out  1  updated with `rpm_out`; 1 if captured count was all-ones (counter may have wrapped).
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset: state IDLE; `count_en`, `done`, `rpm_valid`, `rpm_ovf`, `busy` = 0; `rpm_out` = 0; window counter, multiplier registers = 0.
- IDLE: `run`=1 → GATE (window counter loaded 0). Else stay.
- GATE: `count_en`=1; window counter increments; on the cycle it equals `WINDOW_CYCLES-1` → SAMPLE. `run` is ignored here: a started window always completes.
- SAMPLE: `count_en`=0, `done`=1 for this single cycle; `count_in` captured into operand register on this cycle's edge (counter cannot increment since `count_en`=0; its clear lands on the same edge). Ovf flag captured = (`count_in` == all-ones). → MULT.
- MULT: shift-add, one multiplier bit of `count` per cycle, LSB first, exactly `CNT_W` cycles; accumulator `CNT_W+SCALE_W` bits, no truncation. → OUT.
- OUT: `rpm_out` ← product zero-extended to `RPM_W`, `rpm_ovf` ← captured flag, `rpm_valid`=1 for this cycle. `run`=1 → GATE; else → IDLE.
- Zero pulses → `rpm_out`=0, `rpm_valid` still asserts.
- `rst` mid-operation (any state) → full reset values next cycle; in-flight result discarded, `rpm_out` returns to 0.

## Timing
- All outputs registered (Moore); no combinational path input→output.
- With first GATE cycle = cycle 0: `count_en` high cycles 0..W-1, `done` high cycle W, MULT cycles W+1..W+CNT_W, `rpm_valid` high cycle W+1+CNT_W (W = `WINDOW_CYCLES`).
- Back-to-back: next `count_en` rises cycle W+2+CNT_W; dead time between gates = CNT_W+2 cycles (pulses in dead time not counted, by design).
- `run` sampled only in IDLE and OUT; `run` rising in IDLE → `count_en` high next cycle.
- Pulses edge-detected by the counter with 3-cycle sync latency; edges arriving in the last 3 gate cycles are lost — accepted error, ≤1 pulse.

## Structure
- Package `rpm_pkg`: state enum (IDLE, GATE, SAMPLE, MULT, OUT), default parameter constants (`CNT_W`, `WINDOW_CYCLES`, `RPM_SCALE`, `SCALE_W`, `RPM_W`), shared with the counter and top.
- One sub-module: `shift_add_mult` (start/done handshake, constant multiplicand, `CNT_W`-cycle latency); FSM and window counter stay in `rpm_gate_ctrl`.

## Test plan
(Sim overrides: `WINDOW_CYCLES`=20, defaults otherwise; real pulse counter instanced with `count_en`/`done`.)
- Reset then `run`=1, 5 pulses spaced 3 cycles inside gate → `done` at cycle 20, `rpm_valid` at cycle 25, `rpm_out`=300, `rpm_ovf`=0.
- No pulses, `run`=1 → `rpm_valid` at cycle 25, `rpm_out`=0.
- Drive `count_in`=15 directly at SAMPLE → `rpm_out`=900, `rpm_ovf`=1.
- `run` held high, 2 pulses then 4 pulses in consecutive windows → `rpm_out` 120 then 240; second `count_en` rises cycle 26; `done` is exactly one cycle each window.
- `run` dropped at cycle 5 → window completes, `rpm_valid` at 25, then IDLE with `busy`=0, `count_en` stays 0.
- `rst` asserted at cycle 22 (MULT) → next cycle all outputs 0, state IDLE, no `rpm_valid`; restart yields correct result.
